// File: rtl/mips_pkg.sv
// Shared MIPS encoding types and constants for the instruction encoder slice.
package mips_pkg;

  typedef enum logic [1:0] {
    FMT_R  = 2'd0,
    FMT_I  = 2'd1,
    FMT_J  = 2'd2,
    FMT_LI = 2'd3
  } fmt_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LI2  = 1'b1
  } enc_state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational field packer: fmt + fields -> instruction word, range error, optional LI second word.
// Zero latency; no flow control of its own.
module instr_field_pack
  import mips_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [31:0] imm,
  input  logic [25:0] target,
  output logic [31:0] instr,
  output logic        err,
  output logic        two_word,
  output logic [31:0] instr2
);

  logic hi_zero;
  logic lo_zero;
  logic sext_ok;

  assign hi_zero = (imm[31:16] == 16'h0000);
  assign lo_zero = (imm[15:0] == 16'h0000);
  assign sext_ok = (&imm[31:15]) | ~(|imm[31:15]);

  always_comb begin
    instr    = '0;
    err      = 1'b0;
    two_word = 1'b0;
    instr2   = '0;
    case (fmt)
      FMT_R: instr = {OP_RTYPE, rs, rt, rd, shamt, funct};
      FMT_I: begin
        instr = {opcode, rs, rt, imm[15:0]};
        // Logical immediates and LUI are zero-extended; everything else sign-extends.
        case (opcode)
          OP_ANDI, OP_ORI, OP_XORI, OP_LUI: err = ~hi_zero;
          default:                          err = ~sext_ok;
        endcase
      end
      FMT_J: instr = {opcode, target};
      FMT_LI: begin
        if (sext_ok) begin
          instr = {OP_ADDIU, REG_ZERO, rt, imm[15:0]};
        end else if (hi_zero) begin
          instr = {OP_ORI, REG_ZERO, rt, imm[15:0]};
        end else if (lo_zero) begin
          instr = {OP_LUI, REG_ZERO, rt, imm[31:16]};
        end else begin
          instr    = {OP_LUI, REG_ZERO, rt, imm[31:16]};
          two_word = 1'b1;
          instr2   = {OP_ORI, rt, rt, imm[15:0]};
        end
      end
      default: instr = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs MIPS field tuples into addressed instruction words; LI expands to one or two words.
// Latency 1; output register holds under out_ready=0, input stalls while the LI ORI word is pending.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  fmt_e              in_fmt,
  input  logic [5:0]        in_opcode,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [31:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err
);

  enc_state_e  state;
  logic [31:0] li2_word;
  logic [31:0] pk_instr;
  logic        pk_err;
  logic        pk_two;
  logic [31:0] pk_instr2;
  logic        accept;
  logic        fire;

  instr_field_pack u_pack (
    .fmt      (in_fmt),
    .opcode   (in_opcode),
    .rs       (in_rs),
    .rt       (in_rt),
    .rd       (in_rd),
    .shamt    (in_shamt),
    .funct    (in_funct),
    .imm      (in_imm),
    .target   (in_target),
    .instr    (pk_instr),
    .err      (pk_err),
    .two_word (pk_two),
    .instr2   (pk_instr2)
  );

  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign fire     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
      out_addr  <= ADDR_W'(BASE_ADDR);
      li2_word  <= '0;
    end else begin
      if (fire) begin
        out_addr <= out_addr + ADDR_W'(1);
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            out_valid <= 1'b1;
            out_instr <= pk_instr;
            out_err   <= pk_err;
            if (pk_two) begin
              li2_word <= pk_instr2;
              state    <= S_LI2;
            end
          end else if (fire) begin
            out_valid <= 1'b0;
          end
        end
        S_LI2: begin
          // LUI word is always valid here; the ORI follows directly behind it.
          if (fire) begin
            out_instr <= li2_word;
            out_err   <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder with a 2-bit address counter to exercise wrap.
module tb_instr_encoder;
  import mips_pkg::*;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  fmt_e          in_fmt = FMT_R;
  logic [5:0]    in_opcode = '0;
  logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [5:0]    in_funct = '0;
  logic [31:0]   in_imm = '0;
  logic [25:0]   in_target = '0;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          out_err;

  logic rand_rdy = 1'b0;
  logic rdy_hold = 1'b1;
  logic rnd_rdy  = 1'b0;

  typedef struct packed {
    logic [31:0]   instr;
    logic [AW-1:0] addr;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] exp_addr = '0;
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  assign out_ready = rand_rdy ? rnd_rdy : rdy_hold;

  always @(posedge clk) begin
    #1 rnd_rdy = 1'($urandom_range(0, 1));
  end

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_shamt  (in_shamt),
    .in_funct  (in_funct),
    .in_imm    (in_imm),
    .in_target (in_target),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .out_err   (out_err)
  );

  // Scoreboard consumer: every output handshake pops and checks one expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got instr=%h addr=%0d, expected nothing", out_instr, out_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        if (out_instr !== e.instr) begin
          n_bad++;
          $display("FAIL sb_instr: got %h, expected %h", out_instr, e.instr);
        end
        n_cmp++;
        if (out_addr !== e.addr) begin
          n_bad++;
          $display("FAIL sb_addr: got %0d, expected %0d (instr %h)", out_addr, e.addr, e.instr);
        end
        n_cmp++;
        if (out_err !== e.err) begin
          n_bad++;
          $display("FAIL sb_err: got %b, expected %b (instr %h)", out_err, e.err, e.instr);
        end
      end
    end
  end

  task automatic push(input logic [31:0] w, input logic e);
    exp_t x;
    x.instr = w;
    x.addr  = exp_addr;
    x.err   = e;
    sb.push_back(x);
    exp_addr = exp_addr + 1'b1;
  endtask

  // Reference model written from the encoding tables, independent of the RTL structure.
  task automatic model(input fmt_e f, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                       input logic [31:0] imm, input logic [25:0] tgt);
    int  simm;
    logic ok;
    simm = $signed(imm);
    case (f)
      FMT_R: push({6'h00, rs, rt, rd, sh, fn}, 1'b0);
      FMT_I: begin
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E || op == 6'h0F) ok = (imm < 32'h0001_0000);
        else ok = (simm >= -32768) && (simm <= 32767);
        push({op, rs, rt, imm[15:0]}, !ok);
      end
      FMT_J: push({op, tgt}, 1'b0);
      default: begin
        if (simm >= -32768 && simm <= 32767) push({6'h09, 5'd0, rt, imm[15:0]}, 1'b0);
        else if (imm < 32'h0001_0000) push({6'h0D, 5'd0, rt, imm[15:0]}, 1'b0);
        else if (imm[15:0] == 16'h0) push({6'h0F, 5'd0, rt, imm[31:16]}, 1'b0);
        else begin
          push({6'h0F, 5'd0, rt, imm[31:16]}, 1'b0);
          push({6'h0D, rt, rt, imm[15:0]}, 1'b0);
        end
      end
    endcase
  endtask

  // Presents one tuple until accepted; returns the number of cycles it took.
  task automatic send(input fmt_e f, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [31:0] imm, input logic [25:0] tgt, output int cycles);
    logic acc;
    in_fmt = f; in_opcode = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_funct = fn; in_imm = imm; in_target = tgt;
    in_valid = 1'b1;
    acc = 1'b0;
    cycles = 0;
    while (!acc && cycles < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cycles++;
    end
    in_valid = 1'b0;
    if (acc) model(f, op, rs, rt, rd, sh, fn, imm, tgt);
    else begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready never seen after %0d cycles, expected acceptance", cycles);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d words outstanding, expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    exp_addr = '0;
  endtask

  task automatic test_reset();
    int c;
    rand_rdy = 1'b0;
    rdy_hold = 1'b1;
    do_reset();
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_instr, out_err, out_addr} !== {1'b0, 32'h0, 1'b0, 2'd0}) begin
      n_bad++;
      $display("FAIL reset_outputs: got v=%b i=%h e=%b a=%0d, expected 0/0/0/0",
               out_valid, out_instr, out_err, out_addr);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    c = 0;
  endtask

  task automatic test_formats();
    int c;
    send(FMT_R, 6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 32'h0, 26'h0, c);
    send(FMT_I, OP_ADDIU, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 32'hFFFF_FFFF, 26'h0, c);
    send(FMT_I, OP_ORI, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 32'h0001_0000, 26'h0, c);
    send(FMT_I, OP_ANDI, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 32'h0000_FFFF, 26'h0, c);
    send(FMT_I, OP_ADDIU, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 32'h0000_8000, 26'h0, c);
    send(FMT_J, OP_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 32'h0, 26'h2AB_CDEF, c);
    drain();
  endtask

  task automatic test_li();
    int c;
    send(FMT_LI, 6'h00, 5'd7, 5'd9, 5'd0, 5'd0, 6'h0, 32'h1234_5678, 26'h0, c);
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL li_in_ready: got %b between LUI and ORI, expected 0", in_ready);
    end
    drain();
    send(FMT_LI, 6'h00, 5'd0, 5'd9, 5'd0, 5'd0, 6'h0, 32'h0000_8000, 26'h0, c);
    send(FMT_LI, 6'h00, 5'd0, 5'd9, 5'd0, 5'd0, 6'h0, 32'hABCD_0000, 26'h0, c);
    send(FMT_LI, 6'h00, 5'd0, 5'd10, 5'd0, 5'd0, 6'h0, 32'hFFFF_8000, 26'h0, c);
    drain();
  endtask

  task automatic test_stall();
    int c;
    rdy_hold = 1'b0;
    send(FMT_I, OP_ADDIU, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 32'h0000_1234, 26'h0, c);
    in_fmt = FMT_R; in_rs = 5'd5; in_rt = 5'd6; in_rd = 5'd7; in_shamt = 5'd0; in_funct = 6'h20;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_instr !== 32'h2422_1234 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold: cyc %0d v=%b i=%h rdy=%b, expected 1/24221234/0",
                 i, out_valid, out_instr, in_ready);
      end
    end
    @(posedge clk);
    #1;
    rdy_hold = 1'b1;
    send(FMT_R, 6'h00, 5'd5, 5'd6, 5'd7, 5'd0, 6'h20, 32'h0, 26'h0, c);
    drain();
  endtask

  task automatic test_back_to_back();
    int c;
    rdy_hold = 1'b1;
    send(FMT_R, 6'h00, 5'd1, 5'd1, 5'd1, 5'd1, 6'h01, 32'h0, 26'h0, c);
    for (int i = 0; i < 5; i++) begin
      send(FMT_R, 6'h00, 5'(i), 5'(i + 1), 5'(i + 2), 5'd0, 6'h25, 32'h0, 26'h0, c);
      n_cmp++;
      if (c != 1) begin
        n_bad++;
        $display("FAIL back_to_back: word %0d took %0d cycles, expected 1", i, c);
      end
    end
    drain();
  endtask

  task automatic test_reset_in_li2();
    int c;
    rdy_hold = 1'b0;
    send(FMT_LI, 6'h00, 5'd0, 5'd9, 5'd0, 5'd0, 6'h0, 32'h1234_5678, 26'h0, c);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_instr !== 32'h3C09_1234) begin
      n_bad++;
      $display("FAIL li2_pre_reset: got v=%b i=%h, expected 1/3c091234", out_valid, out_instr);
    end
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || out_addr !== 2'd0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL li2_reset: got v=%b a=%0d rdy=%b, expected 0/0/1", out_valid, out_addr, in_ready);
    end
    @(posedge clk);
    #1;
    rdy_hold = 1'b1;
    send(FMT_R, 6'h00, 5'd4, 5'd5, 5'd6, 5'd2, 6'h00, 32'h0, 26'h0, c);
    drain();
  endtask

  task automatic test_random();
    int c;
    logic [5:0] iops [6];
    iops = '{OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, 6'h23};
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 2);
      if (k == 0)
        send(FMT_R, 6'h00, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
             32'h0, 26'h0, c);
      else if (k == 1)
        send(FMT_I, iops[$urandom_range(0, 5)], 5'($urandom), 5'($urandom), 5'd0, 5'd0, 6'h0,
             ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'($urandom_range(0, 65535)), 26'h0, c);
      else
        send(FMT_J, ($urandom_range(0, 1) != 0) ? OP_J : OP_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0,
             32'h0, 26'($urandom), c);
    end
    drain();
    rand_rdy = 1'b0;
    rdy_hold = 1'b1;
  endtask

  initial begin
    test_reset();
    test_formats();
    test_li();
    test_stall();
    test_back_to_back();
    test_reset_in_li2();
    test_random();
    repeat (5) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
